mod_counter: RTL
================

# mod_counter

Parametrised synchronous modulo-N up/down counter. Successor to the fixed 4-bit free-running counter, adding:
- configurable width and modulus;
- run-time direction;
- parallel load;
- wrap or saturate mode;
- terminal-count, step-pulse and sticky overflow flags.

It is the general-purpose counter for prescalers, timers and address sequencers in the design.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (1..32)
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH
- RESET_VALUE, 0, value of q after reset; must be < MODULUS

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  count enable; one step per clock while high
- up  input  1  direction: 1 = increment, 0 = decrement
- sat  input  1  limit mode: 1 = saturate at limit, 0 = wrap modulo MODULUS
- load  input  1  parallel load strobe
- d  input  WIDTH  load value
- clr_ovf  input  1  clears the sticky overflow flag
- q  output  WIDTH  current count (registered)
- tc  output  1  terminal count for the current direction (combinational)
- step_lim  output  1  one-cycle pulse (registered): an enabled step was attempted at the limit
- ovf  output  1  sticky overflow flag (registered)

## Operation
- Priority per clock edge: rst > load > en. With none active, q holds.
- rst: q=RESET_VALUE, step_lim=0, ovf=0.
- load: q=d if d<MODULUS; otherwise q=MODULUS-1 and ovf is set. en is ignored in a load cycle; step_lim=0.
- en with up=1:
  - q<MODULUS-1: q+1.
  - q=MODULUS-1: q becomes 0 if sat=0, holds at MODULUS-1 if sat=1.
- en with up=0:
  - q>0: q-1.
  - q=0: q becomes MODULUS-1 if sat=0, holds at 0 if sat=1.
- Limit = MODULUS-1 when up=1, 0 when up=0.
- step_lim=1 in the cycle after any enabled, non-load step taken at the limit, in either mode. Otherwise 0.
- ovf is set by a saturated step (sat=1, enabled step at the limit) or by a clamped load.
  - It is cleared by clr_ovf or rst.
  - If set and clr_ovf occur in the same cycle, set wins.
- tc = (up ? q==MODULUS-1 : q==0). It is not gated by en, sat or load.
- Arithmetic:
  - Compute internally at WIDTH+1 bits; q never leaves 0..MODULUS-1.
  - When MODULUS=2**WIDTH, wrap mode equals natural binary rollover.
- up and sat may change every cycle; each takes effect on the edge where it is sampled.

## Timing
- All state changes on the rising edge of clk; latency 1 cycle from input to q/step_lim/ovf.
- tc follows q and up combinationally within the same cycle; it has no clock latency.
- Reset values: q=RESET_VALUE, step_lim=0, ovf=0. tc reflects RESET_VALUE and the current up.
- rst asserted mid-count (with en, load or clr_ovf also active) overrides all of them on that edge.
- Counting resumes on the first edge with rst=0.
- A load at the limit with en=1 produces no step_lim pulse.

## Test plan
All scenarios use WIDTH=4, MODULUS=10, RESET_VALUE=0.
1. Reset then en=1, up=1, sat=0 for 12 cycles -> q=0,1,…,9,0,1. tc high while q=9. step_lim high exactly one cycle, coincident with q=0 after the wrap. ovf stays 0.
2. load d=2, then en=1, up=0, sat=0 for 4 cycles -> q=2,1,0,9,8. tc high at q=0. step_lim pulses with q=9.
3. load d=8, then en=1, up=1, sat=1 for 4 cycles -> q=8,9,9,9. step_lim high for 2 cycles. ovf set after the first saturated step and stays set. A clr_ovf pulse with en=0 clears it.
4. load d=13 -> q=9, ovf=1, step_lim=0. Then saturated step plus clr_ovf in the same cycle -> ovf remains 1.
5. Count up to q=5, then rst=1 for one cycle together with en=1 and load=1 (d=7) -> q=0, ovf=0, step_lim=0 next cycle. Counting resumes 1,2,… once rst=0.
6. en=0 with up toggling -> q holds. tc toggles between (q==9) and (q==0) in the same cycle as up.

Source files
------------

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Parametrised synchronous modulo-N up/down counter with
//               parallel load, wrap/saturate limit mode, a combinational
//               terminal-count flag, a registered step-at-limit pulse and a
//               sticky overflow flag.
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset
//               en       - count enable, one step per clock
//               up       - direction (1 = increment, 0 = decrement)
//               sat      - limit mode (1 = saturate, 0 = wrap)
//               load     - parallel load strobe (wins over en)
//               d        - load value, clamped to MODULUS-1
//               clr_ovf  - clears the sticky overflow flag
//               q        - current count (registered)
//               tc       - terminal count for current direction (comb.)
//               step_lim - one-cycle pulse after a step attempted at limit
//               ovf      - sticky overflow flag (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
   parameter int     WIDTH       = 4,
   parameter longint MODULUS     = 16,
   parameter longint RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             step_lim,
   output logic             ovf
);

   // MODULUS may equal 2**WIDTH, so constants are held at WIDTH+1 bits and
   // MODULUS itself is a 64-bit parameter to allow WIDTH=32.
   localparam logic [WIDTH:0]   c_max_ext = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] c_max     = c_max_ext[WIDTH-1:0];
   localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] c_zero    = '0;

   // Elaboration-time parameter sanity checks.
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_counter: WIDTH out of range 1..32");
   end
   if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS out of range 2..2**WIDTH");
   end
   if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
      $error("mod_counter: RESET_VALUE must be below MODULUS");
   end

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             step_lim_q, step_lim_d;
   logic             ovf_q, ovf_d;

   logic             w_at_lim;
   logic             w_load_clamp;
   logic             w_ovf_set;
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_dec;

   assign w_at_lim     = up ? (cnt_q == c_max) : (cnt_q == c_zero);
   assign w_load_clamp = ({1'b0, d} > c_max_ext);
   assign w_inc        = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
   assign w_dec        = {1'b0, cnt_q} - {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      cnt_d      = cnt_q;
      step_lim_d = 1'b0;
      w_ovf_set  = 1'b0;

      if (load) begin
         if (w_load_clamp) begin
            cnt_d     = c_max;
            w_ovf_set = 1'b1;
         end else begin
            cnt_d = d;
         end
      end else if (en) begin
         if (w_at_lim) begin
            step_lim_d = 1'b1;
            if (sat) begin
               // Saturate: count holds at the limit and overflow is flagged.
               w_ovf_set = 1'b1;
            end else begin
               cnt_d = up ? c_zero : c_max;
            end
         end else begin
            // Away from the limit the WIDTH+1-bit result never overflows
            // WIDTH bits, so the truncation is exact.
            cnt_d = up ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
         end
      end

      // A set in the same cycle as clr_ovf wins.
      if (w_ovf_set) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= c_rst_val;
         step_lim_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         step_lim_q <= step_lim_d;
         ovf_q      <= ovf_d;
      end
   end

   assign q        = cnt_q;
   assign tc       = up ? (cnt_q == c_max) : (cnt_q == c_zero);
   assign step_lim = step_lim_q;
   assign ovf      = ovf_q;

endmodule
`default_nettype wire
